// File: rtl/mcp3002_follower.sv
// -----------------------------------------------------------------------------
// mcp3002_follower
//   Emulates an MCP3002 10-bit, 2-channel ADC on an SPI bus. The bus pins are
//   oversampled on CLK_50MHz; SCLK is treated as data and never used as a clock.
//   The conversion result comes from ch0_data/ch1_data. It is latched once per
//   frame, when the ODD/SIGN configuration bit is captured.
//
// Ports
//   CLK_50MHz   in   system clock, all logic on posedge
//   RESET       in   asynchronous active-low reset
//   SCLK        in   bus clock from the leader (asynchronous, oversampled)
//   CS          in   chip select, active low
//   Din         in   configuration bits, sampled on SCLK rise
//   ch0_data    in   CH0 sample value
//   ch1_data    in   CH1 sample value
//   Dout        out  serial result, updated on SCLK fall
//   Dout_oe     out  1 = drive Dout, 0 = release the bus
//   conv_ch     out  ODD/SIGN bit of the last accepted configuration
//   conv_sgl    out  SGL/DIFF bit of the last accepted configuration
//   frame_done  out  1-cycle pulse: CS rose after all result bits were sent
//   frame_abort out  1-cycle pulse: CS rose mid-frame, before the last result bit
// -----------------------------------------------------------------------------
module mcp3002_follower #(
  parameter int DATA_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_50MHz,
  input  logic                 RESET,
  input  logic                 SCLK,
  input  logic                 CS,
  input  logic                 Din,
  input  logic [DATA_BITS-1:0] ch0_data,
  input  logic [DATA_BITS-1:0] ch1_data,
  output logic                 Dout,
  output logic                 Dout_oe,
  output logic                 conv_ch,
  output logic                 conv_sgl,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_CFG      = 3'd2;
  localparam logic [2:0] ST_NULL     = 3'd3;
  localparam logic [2:0] ST_DATA_MSB = 3'd4;
  localparam logic [2:0] ST_DATA_LSB = 3'd5;
  localparam logic [2:0] ST_HOLD     = 3'd6;

  // Synchroniser chains plus one history flop per line for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s;
  logic cs_s;
  logic din_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  // Frame state
  logic [2:0]           state_q,    state_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic                 sgl_q,      sgl_d;
  logic                 msbf_q,     msbf_d;
  logic [DATA_BITS-1:0] result_q,   result_d;

  // Registered outputs
  logic dout_q,        dout_d;
  logic dout_oe_q,     dout_oe_d;
  logic conv_ch_q,     conv_ch_d;
  logic conv_sgl_q,    conv_sgl_d;
  logic frame_done_q,  frame_done_d;
  logic frame_abort_q, frame_abort_d;

  // Candidate conversion value for the ODD bit currently on the Din line
  logic [DATA_BITS-1:0] pick_a;
  logic [DATA_BITS-1:0] pick_b;
  logic [DATA_BITS-1:0] sample_val;

  // Bring the bus lines into the CLK_50MHz domain.
  // The CS chain resets low. If CS is held low through reset, no falling edge
  // appears afterwards, so a frame can only start on a fresh CS fall.
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b0}};
      din_sync_q  <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], Din};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Select the conversion value: single-ended picks a channel, differential
  // subtracts and clamps negative results to zero.
  always_comb begin
    pick_a     = din_s ? ch1_data : ch0_data;
    pick_b     = din_s ? ch0_data : ch1_data;
    sample_val = {DATA_BITS{1'b0}};
    if (sgl_q) begin
      sample_val = pick_a;
    end else if (pick_a > pick_b) begin
      sample_val = pick_a - pick_b;
    end else begin
      sample_val = {DATA_BITS{1'b0}};
    end
  end

  // Frame sequencing: configuration decode and result shifting
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sgl_d         = sgl_q;
    msbf_d        = msbf_q;
    result_d      = result_q;
    dout_d        = dout_q;
    dout_oe_d     = dout_oe_q;
    conv_ch_d     = conv_ch_q;
    conv_sgl_d    = conv_sgl_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;

    if (cs_rise) begin
      // A CS rise ends the frame and takes priority over any SCLK edge seen in the same cycle.
      state_d   = ST_IDLE;
      bit_cnt_d = CNT_ZERO;
      dout_d    = 1'b0;
      dout_oe_d = 1'b0;
      case (state_q)
        ST_HOLD:     frame_done_d  = 1'b1;
        ST_CFG,
        ST_NULL,
        ST_DATA_MSB,
        ST_DATA_LSB: frame_abort_d = 1'b1;
        default:     frame_done_d  = 1'b0;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_oe_d = 1'b0;
          if (cs_fall) begin
            state_d   = ST_START;
            bit_cnt_d = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_START: begin
          // Leading zeros before the start bit are legal.
          if (sclk_rise && din_s) begin
            state_d   = ST_CFG;
            bit_cnt_d = CNT_ZERO;
          end else begin
            state_d = ST_START;
          end
        end

        ST_CFG: begin
          if (sclk_rise) begin
            case (bit_cnt_q)
              CNT_ZERO: begin
                sgl_d     = din_s;
                bit_cnt_d = CNT_ONE;
              end
              CNT_ONE: begin
                result_d   = sample_val;
                conv_sgl_d = sgl_q;
                conv_ch_d  = din_s;
                bit_cnt_d  = CNT_W'(2);
              end
              default: begin
                msbf_d    = din_s;
                bit_cnt_d = CNT_ZERO;
                state_d   = ST_NULL;
              end
            endcase
          end else begin
            state_d = ST_CFG;
          end
        end

        ST_NULL: begin
          if (sclk_fall) begin
            dout_oe_d = 1'b1;
            dout_d    = 1'b0;
            bit_cnt_d = CNT_MSB;
            state_d   = ST_DATA_MSB;
          end else begin
            state_d = ST_NULL;
          end
        end

        ST_DATA_MSB: begin
          if (sclk_fall) begin
            dout_d = result_q[bit_cnt_q];
            if (bit_cnt_q == CNT_ZERO) begin
              // B0 is shared between the MSB-first and LSB-first halves.
              bit_cnt_d = CNT_ONE;
              state_d   = msbf_q ? ST_HOLD : ST_DATA_LSB;
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_ONE;
            end
          end else begin
            state_d = ST_DATA_MSB;
          end
        end

        ST_DATA_LSB: begin
          if (sclk_fall) begin
            dout_d = result_q[bit_cnt_q];
            if (bit_cnt_q == CNT_MSB) begin
              bit_cnt_d = CNT_ZERO;
              state_d   = ST_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_DATA_LSB;
          end
        end

        ST_HOLD: begin
          if (sclk_fall) begin
            dout_d = 1'b0;
          end else begin
            dout_d = dout_q;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = CNT_ZERO;
          dout_d    = 1'b0;
          dout_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK_50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= CNT_ZERO;
      sgl_q         <= 1'b0;
      msbf_q        <= 1'b0;
      result_q      <= {DATA_BITS{1'b0}};
      dout_q        <= 1'b0;
      dout_oe_q     <= 1'b0;
      conv_ch_q     <= 1'b0;
      conv_sgl_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sgl_q         <= sgl_d;
      msbf_q        <= msbf_d;
      result_q      <= result_d;
      dout_q        <= dout_d;
      dout_oe_q     <= dout_oe_d;
      conv_ch_q     <= conv_ch_d;
      conv_sgl_q    <= conv_sgl_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign Dout        = dout_q;
  assign Dout_oe     = dout_oe_q;
  assign conv_ch     = conv_ch_q;
  assign conv_sgl    = conv_sgl_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_mcp3002_follower.sv
// -----------------------------------------------------------------------------
// tb_mcp3002_follower
//   Directed bench for mcp3002_follower. It drives SPI frames bit by bit,
//   collects the Dout stream sampled just before each SCLK rise, and compares
//   it with hand-computed streams.
// -----------------------------------------------------------------------------
module tb_mcp3002_follower;

  logic       CLK_50MHz;
  logic       RESET;
  logic       SCLK;
  logic       CS;
  logic       Din;
  logic [9:0] ch0_data;
  logic [9:0] ch1_data;
  logic       Dout;
  logic       Dout_oe;
  logic       conv_ch;
  logic       conv_sgl;
  logic       frame_done;
  logic       frame_abort;

  int n_checks;
  int n_pass;
  int done_cnt;
  int abort_cnt;

  mcp3002_follower #(.DATA_BITS(10), .SYNC_STAGES(2)) dut (
    .CLK_50MHz  (CLK_50MHz),
    .RESET      (RESET),
    .SCLK       (SCLK),
    .CS         (CS),
    .Din        (Din),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .Dout       (Dout),
    .Dout_oe    (Dout_oe),
    .conv_ch    (conv_ch),
    .conv_sgl   (conv_sgl),
    .frame_done (frame_done),
    .frame_abort(frame_abort)
  );

  initial CLK_50MHz = 1'b0;
  always #10 CLK_50MHz = ~CLK_50MHz;

  // Count every cycle in which a pulse output is high, sampled on the quiet edge
  always @(negedge CLK_50MHz) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_50MHz);
    #1;
  endtask

  // One SCLK period: Din set during low phase, Dout sampled just before the rise
  task automatic clk_bit(input logic b, output logic d, output logic oe);
    Din = b;
    cyc(8);
    d  = Dout;
    oe = Dout_oe;
    SCLK = 1'b1;
    cyc(8);
    SCLK = 1'b0;
  endtask

  task automatic frame(input int lead0, input logic sgl, input logic odd, input logic msbf,
                       input int ndata, output logic [31:0] stream, output logic oe_all);
    logic d;
    logic oe;
    stream = 32'd0;
    oe_all = 1'b1;
    CS = 1'b0;
    cyc(8);
    for (int i = 0; i < lead0; i++) clk_bit(1'b0, d, oe);
    clk_bit(1'b1, d, oe);
    clk_bit(sgl, d, oe);
    clk_bit(odd, d, oe);
    clk_bit(msbf, d, oe);
    for (int i = 0; i < ndata; i++) begin
      clk_bit(1'b1, d, oe);
      stream = {stream[30:0], d};
      oe_all = oe_all & oe;
    end
  endtask

  task automatic cs_up(input string tag, input int exp_done, input int exp_abort);
    int d0;
    int a0;
    cyc(8);
    d0 = done_cnt;
    a0 = abort_cnt;
    CS = 1'b1;
    cyc(3);
    check_eq({tag, "_oe_off"}, {31'd0, Dout_oe}, 32'd0);
    check_eq({tag, "_dout_off"}, {31'd0, Dout}, 32'd0);
    cyc(7);
    check_eq({tag, "_done"}, done_cnt - d0, exp_done);
    check_eq({tag, "_abort"}, abort_cnt - a0, exp_abort);
  endtask

  logic [31:0] stream;
  logic        oe_all;
  logic        d_x;
  logic        oe_x;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    done_cnt  = 0;
    abort_cnt = 0;
    RESET     = 1'b1;
    SCLK      = 1'b0;
    CS        = 1'b0;
    Din       = 1'b0;
    ch0_data  = 10'd0;
    ch1_data  = 10'd0;
    #1;
    RESET = 1'b0;
    cyc(2);

    // Reset held with CS low and SCLK toggling
    for (int i = 0; i < 4; i++) clk_bit(1'b1, d_x, oe_x);
    check_eq("rst_oe", {31'd0, Dout_oe}, 32'd0);
    check_eq("rst_dout", {31'd0, Dout}, 32'd0);
    check_eq("rst_conv_ch", {31'd0, conv_ch}, 32'd0);
    check_eq("rst_conv_sgl", {31'd0, conv_sgl}, 32'd0);
    check_eq("rst_pulses", done_cnt + abort_cnt, 32'd0);

    // Release reset with CS still low: no frame without a fresh CS fall
    RESET = 1'b1;
    for (int i = 0; i < 16; i++) clk_bit(1'b1, d_x, oe_x);
    check_eq("norestart_oe", {31'd0, oe_x}, 32'd0);
    check_eq("norestart_pulses", done_cnt + abort_cnt, 32'd0);
    cs_up("norestart_csup", 0, 0);

    // Single-ended CH1, MSB first
    ch0_data = 10'h155;
    ch1_data = 10'h2A5;
    frame(0, 1'b1, 1'b1, 1'b1, 12, stream, oe_all);
    check_eq("sgl_ch1_msbf_stream", stream, {20'd0, 1'b0, 10'h2A5, 1'b0});
    check_eq("sgl_ch1_msbf_oe", {31'd0, oe_all}, 32'd1);
    check_eq("sgl_ch1_conv_ch", {31'd0, conv_ch}, 32'd1);
    check_eq("sgl_ch1_conv_sgl", {31'd0, conv_sgl}, 32'd1);
    cs_up("sgl_ch1_msbf_end", 1, 0);

    // Same with LSB-first tail (B1..B9 of 1010100101 are 0,1,0,0,1,0,1,0,1)
    frame(0, 1'b1, 1'b1, 1'b0, 21, stream, oe_all);
    check_eq("sgl_ch1_lsbf_stream", stream, {11'd0, 1'b0, 10'h2A5, 9'b010010101, 1'b0});
    check_eq("sgl_ch1_lsbf_oe", {31'd0, oe_all}, 32'd1);
    cs_up("sgl_ch1_lsbf_end", 1, 0);

    // Differential CH0-CH1 = 300-100 = 200
    ch0_data = 10'd300;
    ch1_data = 10'd100;
    frame(0, 1'b0, 1'b0, 1'b1, 12, stream, oe_all);
    check_eq("diff_pos_stream", stream, {20'd0, 1'b0, 10'd200, 1'b0});
    check_eq("diff_pos_conv_sgl", {31'd0, conv_sgl}, 32'd0);
    check_eq("diff_pos_conv_ch", {31'd0, conv_ch}, 32'd0);
    cs_up("diff_pos_end", 1, 0);

    // Differential CH1-CH0 = 100-300 clamps to 0
    frame(0, 1'b0, 1'b1, 1'b1, 12, stream, oe_all);
    check_eq("diff_neg_stream", stream, 32'd0);
    check_eq("diff_neg_conv_ch", {31'd0, conv_ch}, 32'd1);
    cs_up("diff_neg_end", 1, 0);

    // Two leading zeros before the start bit
    ch1_data = 10'h2A5;
    frame(2, 1'b1, 1'b1, 1'b1, 12, stream, oe_all);
    check_eq("lead0_stream", stream, {20'd0, 1'b0, 10'h2A5, 1'b0});
    cs_up("lead0_end", 1, 0);

    // Abort after null bit plus 8 result bits
    frame(0, 1'b1, 1'b1, 1'b1, 9, stream, oe_all);
    check_eq("abort_stream", stream, {23'd0, 1'b0, 8'b10101001});
    cs_up("abort_end", 0, 1);

    // Next frame after the abort: single-ended CH0 = 300
    ch0_data = 10'd300;
    frame(0, 1'b1, 1'b0, 1'b1, 12, stream, oe_all);
    check_eq("post_abort_stream", stream, {20'd0, 1'b0, 10'd300, 1'b0});
    check_eq("post_abort_conv_ch", {31'd0, conv_ch}, 32'd0);
    cs_up("post_abort_end", 1, 0);

    // CS rise while still waiting for the start bit: no pulse
    CS = 1'b0;
    cyc(8);
    clk_bit(1'b0, d_x, oe_x);
    check_eq("start_oe", {31'd0, oe_x}, 32'd0);
    cs_up("start_end", 0, 0);

    // Asynchronous reset mid-frame
    frame(0, 1'b1, 1'b1, 1'b1, 5, stream, oe_all);
    check_eq("midrst_pre_oe", {31'd0, Dout_oe}, 32'd1);
    RESET = 1'b0;
    #1;
    check_eq("midrst_oe", {31'd0, Dout_oe}, 32'd0);
    check_eq("midrst_conv_ch", {31'd0, conv_ch}, 32'd0);
    cyc(2);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) clk_bit(1'b1, d_x, oe_x);
    check_eq("midrst_after_oe", {31'd0, oe_x}, 32'd0);
    cs_up("midrst_end", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
